// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader
// and the CPU's IM write port.
package imem_loader_pkg;

  localparam int IM_ADDR_W      = 8;
  localparam int IM_DEPTH_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    BYTES = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian 8->32 shift register with a 2-bit byte counter.
// word_full flags the shift that completes a 4-byte word.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  assign word_full = shift_en && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (clr) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      word     <= {word[23:0], in_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a length-prefixed byte stream while
// holding the CPU; all outputs are registered from the next state.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = IM_ADDR_W,
  parameter int DEPTH_WORDS = IM_DEPTH_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_err,
  output logic [7:0]        words_left
);

  localparam logic [7:0] MAX_LEN = 8'(DEPTH_WORDS);

  state_t state, state_next;

  // One extra bit so the index can reach DEPTH_WORDS after the last write.
  logic [ADDR_W-2:0] word_idx;
  logic [31:0]       word;
  logic              word_full;
  logic              xfer;
  logic              shift_en;
  logic              clr;
  logic              load_len;

  assign xfer     = in_valid && in_ready;
  assign shift_en = (state == BYTES) && xfer;
  assign clr      = (state == HDR) && xfer;

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .shift_en  (shift_en),
    .in_data   (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state;
    load_len   = 1'b0;
    case (state)
      IDLE:  if (ld_start) state_next = HDR;
      HDR: begin
        if (xfer) begin
          if (in_data == 8'd0 || in_data > MAX_LEN) begin
            state_next = ERR;
          end else begin
            load_len   = 1'b1;
            state_next = BYTES;
          end
        end
      end
      BYTES: if (word_full) state_next = WRITE;
      WRITE: state_next = (words_left == 8'd1) ? DONE : BYTES;
      DONE:  state_next = IDLE;
      ERR:   if (ld_start) state_next = HDR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b0;
      ld_done    <= 1'b0;
      ld_err     <= 1'b0;
      words_left <= '0;
      word_idx   <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == HDR) || (state_next == BYTES);
      cpu_hold <= (state_next == HDR) || (state_next == BYTES) ||
                  (state_next == WRITE) || (state_next == ERR);
      ld_err   <= (state_next == ERR);
      ld_done  <= (state_next == DONE);
      im_we    <= (state_next == WRITE);
      // WRITE is only entered on the 4th byte, so that byte is still on in_data.
      im_addr  <= (state_next == WRITE) ? {word_idx[ADDR_W-3:0], 2'b00} : '0;
      im_wdata <= (state_next == WRITE) ? {word[23:0], in_data} : '0;
      if (load_len) begin
        words_left <= in_data;
        word_idx   <= '0;
      end else if (state == WRITE) begin
        words_left <= words_left - 8'd1;
        word_idx   <= word_idx + 1'b1;
      end
    end
  end

endmodule
